// File: rtl/register_unit.sv
// Virgule integer register file: two combinational read ports, one write port, x0 hard-wired to zero.
// Optional write-to-read forwarding is enabled by defining REGISTER_UNIT_BYPASS_EN.

typedef logic [31:0] word_t;
typedef logic [4:0]  register_index_t;

typedef struct packed {
    logic [6:0]      opcode;
    register_index_t rd;
    logic            has_rd;
    register_index_t rs1;
    register_index_t rs2;
    logic [11:0]     imm;
} instruction_t;

module register_unit #(
    parameter int size = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  instruction_t src_instr,
    input  instruction_t dest_instr,
    input  word_t        xd,
    output word_t        xs1,
    output word_t        xs2
);

    word_t regs_q [size];
    word_t regs_d [size];
    logic  wr_en_s;

    // x0 and out-of-range indices never hold data and always read as zero.
    function automatic logic idx_valid(input register_index_t idx);
        return (idx != 5'd0) && (int'(idx) < size);
    endfunction

    // Only the register index fields of the instructions matter here.
    logic unused_fields_s;
    assign unused_fields_s = ^{src_instr.opcode, src_instr.rd, src_instr.has_rd, src_instr.imm,
                               dest_instr.opcode, dest_instr.rs1, dest_instr.rs2, dest_instr.imm};

    // Write qualification and next-state of the register array.
    always_comb begin
        regs_d  = regs_q;
        wr_en_s = enable && dest_instr.has_rd && idx_valid(dest_instr.rd);
        if (wr_en_s) begin
            regs_d[dest_instr.rd] = xd;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < size; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports, with same-cycle forwarding when the bypass build is selected.
    always_comb begin
        xs1 = 32'h0000_0000;
        xs2 = 32'h0000_0000;
        if (idx_valid(src_instr.rs1)) begin
            xs1 = regs_q[src_instr.rs1];
        end else begin
            xs1 = 32'h0000_0000;
        end
        if (idx_valid(src_instr.rs2)) begin
            xs2 = regs_q[src_instr.rs2];
        end else begin
            xs2 = 32'h0000_0000;
        end
`ifdef REGISTER_UNIT_BYPASS_EN
        if (wr_en_s && (dest_instr.rd == src_instr.rs1)) begin
            xs1 = xd;
        end else begin
            xs1 = xs1;
        end
        if (wr_en_s && (dest_instr.rd == src_instr.rs2)) begin
            xs2 = xd;
        end else begin
            xs2 = xs2;
        end
`endif
    end

endmodule

// File: tb/tb_register_unit.sv
// Directed, table-driven bench for register_unit.
module tb_register_unit;

    logic         clk;
    logic         reset;
    logic         enable;
    instruction_t src_instr;
    instruction_t dest_instr;
    word_t        xd;
    word_t        xs1;
    word_t        xs2;

    int checks;
    int failures;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } rd_vec_t;

    rd_vec_t vecs [16];

    register_unit #(.size(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .src_instr  (src_instr),
        .dest_instr (dest_instr),
        .xd         (xd),
        .xs1        (xs1),
        .xs2        (xs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_read(input logic [4:0] r1, input logic [4:0] r2);
        src_instr        = '0;
        src_instr.opcode = 7'($urandom);
        src_instr.imm    = 12'($urandom);
        src_instr.rd     = 5'($urandom);
        src_instr.has_rd = 1'($urandom);
        src_instr.rs1    = r1;
        src_instr.rs2    = r2;
    endtask

    task automatic set_write(input logic en, input logic [4:0] rd, input logic hrd, input logic [31:0] d);
        dest_instr        = '0;
        dest_instr.opcode = 7'($urandom);
        dest_instr.imm    = 12'($urandom);
        dest_instr.rs1    = 5'($urandom);
        dest_instr.rs2    = 5'($urandom);
        dest_instr.rd     = rd;
        dest_instr.has_rd = hrd;
        enable            = en;
        xd                = d;
    endtask

    // Apply a write at the next rising edge, then return at the following falling edge.
    task automatic do_write(input logic en, input logic [4:0] rd, input logic hrd, input logic [31:0] d);
        set_write(en, rd, hrd, d);
        @(posedge clk);
        @(negedge clk);
        set_write(1'b0, 5'd0, 1'b0, 32'h0000_0000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_read(5'd1, 5'd31);
        set_write(1'b1, 5'd1, 1'b1, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        check("reset_xs1", xs1, 32'h0000_0000);
        check("reset_xs2", xs2, 32'h0000_0000);
        reset = 1'b0;
        set_write(1'b0, 5'd0, 1'b0, 32'h0000_0000);

        // Load every register with (n+1)<<12; x0 write is attempted with has_rd low.
        for (int n = 0; n < 32; n++) begin
            do_write(1'b1, 5'(n), (n > 0), 32'((n + 1) << 12));
        end

        vecs[0]  = '{5'd0,  5'd1,  32'h0000_0000, 32'h0000_2000};
        vecs[1]  = '{5'd2,  5'd3,  32'h0000_3000, 32'h0000_4000};
        vecs[2]  = '{5'd4,  5'd5,  32'h0000_5000, 32'h0000_6000};
        vecs[3]  = '{5'd6,  5'd7,  32'h0000_7000, 32'h0000_8000};
        vecs[4]  = '{5'd8,  5'd9,  32'h0000_9000, 32'h0000_A000};
        vecs[5]  = '{5'd10, 5'd11, 32'h0000_B000, 32'h0000_C000};
        vecs[6]  = '{5'd12, 5'd13, 32'h0000_D000, 32'h0000_E000};
        vecs[7]  = '{5'd14, 5'd15, 32'h0000_F000, 32'h0001_0000};
        vecs[8]  = '{5'd16, 5'd17, 32'h0001_1000, 32'h0001_2000};
        vecs[9]  = '{5'd18, 5'd19, 32'h0001_3000, 32'h0001_4000};
        vecs[10] = '{5'd20, 5'd21, 32'h0001_5000, 32'h0001_6000};
        vecs[11] = '{5'd22, 5'd23, 32'h0001_7000, 32'h0001_8000};
        vecs[12] = '{5'd24, 5'd25, 32'h0001_9000, 32'h0001_A000};
        vecs[13] = '{5'd26, 5'd27, 32'h0001_B000, 32'h0001_C000};
        vecs[14] = '{5'd28, 5'd29, 32'h0001_D000, 32'h0001_E000};
        vecs[15] = '{5'd30, 5'd31, 32'h0001_F000, 32'h0002_0000};

        for (int i = 0; i < 16; i++) begin
            set_read(vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("table%0d_xs1", i), xs1, vecs[i].exp1);
            check($sformatf("table%0d_xs2", i), xs2, vecs[i].exp2);
        end

        // Suppressed writes to x5.
        do_write(1'b0, 5'd5, 1'b1, 32'hDEAD_BEEF);
        set_read(5'd5, 5'd5);
        #1;
        check("x5_enable_low", xs1, 32'h0000_6000);
        do_write(1'b1, 5'd5, 1'b0, 32'hDEAD_BEEF);
        set_read(5'd5, 5'd4);
        #1;
        check("x5_has_rd_low", xs1, 32'h0000_6000);

        // x0 stays zero even on a fully qualified write.
        do_write(1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF);
        set_read(5'd0, 5'd0);
        #1;
        check("x0_write_xs1", xs1, 32'h0000_0000);
        check("x0_write_xs2", xs2, 32'h0000_0000);

        // Both ports on the same register.
        do_write(1'b1, 5'd7, 1'b1, 32'h1234_5678);
        set_read(5'd7, 5'd7);
        #1;
        check("dual_x7_xs1", xs1, 32'h1234_5678);
        check("dual_x7_xs2", xs2, 32'h1234_5678);

        // Same-cycle write and read of x3.
        set_read(5'd3, 5'd2);
        set_write(1'b1, 5'd3, 1'b1, 32'hA5A5_A5A5);
        #1;
`ifdef REGISTER_UNIT_BYPASS_EN
        check("x3_same_cycle", xs1, 32'hA5A5_A5A5);
`else
        check("x3_same_cycle", xs1, 32'h0000_4000);
`endif
        check("x3_same_cycle_xs2", xs2, 32'h0000_3000);
        @(posedge clk);
        @(negedge clk);
        set_write(1'b0, 5'd0, 1'b0, 32'h0000_0000);
        #1;
        check("x3_after_edge", xs1, 32'hA5A5_A5A5);

        // Asynchronous reset between edges, with a pending write it must override.
        set_read(5'd31, 5'd7);
        set_write(1'b1, 5'd31, 1'b1, 32'hCAFE_F00D);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_xs1", xs1, 32'h0000_0000);
        check("async_reset_xs2", xs2, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        check("reset_over_write", xs1, 32'h0000_0000);
        reset = 1'b0;
        set_write(1'b0, 5'd0, 1'b0, 32'h0000_0000);
        set_read(5'd3, 5'd5);
        #1;
        check("post_reset_x3", xs1, 32'h0000_0000);
        check("post_reset_x5", xs2, 32'h0000_0000);

        // Write still works after reset release.
        do_write(1'b1, 5'd31, 1'b1, 32'h0BAD_F00D);
        set_read(5'd31, 5'd30);
        #1;
        check("rewrite_x31", xs1, 32'h0BAD_F00D);
        check("rewrite_x30", xs2, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
